countdown_timer: RTL

Programmable seconds countdown timer. It consumes the one-cycle `one_hz_enable` strobe produced by the design's clock divider and counts a loaded value down to zero. When the count reaches zero it signals expiry. On every start it issues a realignment pulse back to the divider, so the first counted second is a full period. It sits between the control FSMs, which load and start it, and the divider.

---
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer.sv | 99 +++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control-side bundle for countdown_timer: load/start/pause/abort and tick in,
// count status and divider realignment out.
interface countdown_timer_if #(
   parameter int unsigned WIDTH = 4
);
   logic             one_hz_enable;
   logic             start_timer;
   logic [WIDTH-1:0] value;
   logic             pause;
   logic             abort;
   logic             divider_reset;
   logic [WIDTH-1:0] remaining;
   logic             busy;
   logic             done;
   logic             expired;

   modport master (
      output one_hz_enable, start_timer, value, pause, abort,
      input  divider_reset, remaining, busy, done, expired
   );

   modport slave (
      input  one_hz_enable, start_timer, value, pause, abort,
      output divider_reset, remaining, busy, done, expired
   );
endinterface

// File: rtl/countdown_timer.sv
// Programmable seconds countdown timer driven by the divider's 1 Hz strobe,
// with optional auto-reload and a divider realignment pulse on every start.
module countdown_timer #(
   parameter int unsigned WIDTH       = 4,
   parameter bit          AUTO_RELOAD = 1'b0
) (
   input  logic           clock,
   input  logic           reset,
   countdown_timer_if.slave tmr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUNNING,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0] latched_q, latched_d;
   logic             expired_q, expired_d;
   logic             divrst_q, divrst_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         latched_q   <= '0;
         expired_q   <= 1'b0;
         divrst_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         latched_q   <= latched_d;
         expired_q   <= expired_d;
         divrst_q    <= divrst_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      latched_d   = latched_q;
      expired_d   = 1'b0;
      divrst_d    = 1'b0;

      if (tmr.start_timer) begin
         latched_d   = tmr.value;
         remaining_d = tmr.value;
         divrst_d    = 1'b1;
         if (tmr.value == '0) begin
            state_d   = S_DONE;
            expired_d = 1'b1;
         end else begin
            state_d   = S_RUNNING;
         end
      end else if (tmr.abort) begin
         state_d     = S_IDLE;
         remaining_d = '0;
      end else begin
         unique case (state_q)
            S_RUNNING: begin
               // remaining==0 while RUNNING only occurs in the single visible
               // zero cycle after an auto-reload expiry; refill from the latch.
               if (remaining_q == '0) begin
                  remaining_d = latched_q;
                  if (tmr.pause) state_d = S_PAUSED;
               end else if (tmr.pause) begin
                  state_d = S_PAUSED;
               end else if (tmr.one_hz_enable) begin
                  if (remaining_q == WIDTH'(1)) begin
                     remaining_d = '0;
                     expired_d   = 1'b1;
                     if (!AUTO_RELOAD) state_d = S_DONE;
                  end else begin
                     remaining_d = remaining_q - WIDTH'(1);
                  end
               end
            end
            S_PAUSED: begin
               if (!tmr.pause) state_d = S_RUNNING;
            end
            S_DONE: begin
               remaining_d = '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign tmr.remaining     = remaining_q;
   assign tmr.expired       = expired_q;
   assign tmr.divider_reset = divrst_q;
   assign tmr.busy          = (state_q == S_RUNNING) || (state_q == S_PAUSED);
   assign tmr.done          = (state_q == S_DONE);

endmodule
